neuron_mac: RTL

NEURON_MAC -- requirements
Module: neuron_mac

---
 rtl/nn_pkg.sv | 38 +++
 rtl/fxp_mul_q16.sv | 41 ++++
 rtl/neuron_mac.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared constants, FSM state type and result saturation for the neuron MAC.
// Q16.16 fixed point throughout; the accumulator is kept at double width.
package nn_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 10;
  localparam int FRAC   = 16;
  localparam int ACC_W  = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [ACC_W-1:0] SAT_MIN = 64'shFFFF_FFFF_8000_0000;

  // Clamp the wide accumulator into DATA_W, then optionally apply ReLU.
  function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] value,
                                                 input logic relu);
    logic signed [ACC_W-1:0] clamped;
    if (value > SAT_MAX) begin
      clamped = SAT_MAX;
    end else if (value < SAT_MIN) begin
      clamped = SAT_MIN;
    end else begin
      clamped = value;
    end
    if (relu && (clamped < 0)) begin
      clamped = '0;
    end
    return clamped[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fxp_mul_q16.sv
// Registered signed DATA_W x DATA_W multiply with an arithmetic right shift
// by FRAC, producing a full-width product stage with its own valid bit.
module fxp_mul_q16
  import nn_pkg::*;
#(
  parameter int DATA_W = nn_pkg::DATA_W,
  parameter int FRAC   = nn_pkg::FRAC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          a,
  input  logic [DATA_W-1:0]          b,
  output logic                       out_valid,
  output logic signed [2*DATA_W-1:0] p
);

  logic signed [2*DATA_W-1:0] a_ext;
  logic signed [2*DATA_W-1:0] b_ext;
  logic signed [2*DATA_W-1:0] full;

  // Sign-extend explicitly so the multiply is done at full product width.
  assign a_ext = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_ext = {{DATA_W{b[DATA_W-1]}}, b};
  assign full  = a_ext * b_ext;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      p         <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        p <= full >>> FRAC;
      end
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Streaming dot-product neuron: reads one weight per accepted activation,
// multiplies in Q16.16, accumulates, then presents a saturated result.
module neuron_mac
  import nn_pkg::*;
#(
  parameter int ADDR_W = nn_pkg::ADDR_W,
  parameter int DATA_W = nn_pkg::DATA_W,
  parameter int CNT_W  = nn_pkg::CNT_W,
  parameter int FRAC   = nn_pkg::FRAC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_inputs,
  input  logic              relu_en,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              act_valid,
  input  logic [DATA_W-1:0] act_data,
  output logic              act_ready,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_ready
);

  state_t state;
  state_t next_state;

  logic [ADDR_W-1:0]          base_q;
  logic [CNT_W-1:0]           n_q;
  logic                       relu_q;
  logic [CNT_W-1:0]           idx;
  logic [DATA_W-1:0]          act_q;
  logic                       act_q_valid;
  logic                       mul_valid;
  logic signed [2*DATA_W-1:0] mul_p;
  logic signed [2*DATA_W-1:0] acc;
  logic                       fire;

  assign fire   = act_valid && act_ready;
  assign ram_we = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (num_inputs == '0) ? RESULT : RUN;
        end
      end
      RUN: begin
        if (fire && ((idx + CNT_W'(1)) == n_q)) begin
          next_state = DRAIN;
        end
      end
      // Wait until the last product has landed in the accumulator.
      DRAIN: begin
        if (!act_q_valid && !mul_valid) begin
          next_state = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the block
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    busy      = (state != IDLE);
    act_ready = (state == RUN) && (idx < n_q);
    res_valid = (state == RESULT);
    ram_en    = act_valid && act_ready;
    ram_addr  = '0;
    if (ram_en) begin
      ram_addr = base_q + ADDR_W'(idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q      <= '0;
      n_q         <= '0;
      relu_q      <= 1'b0;
      idx         <= '0;
      act_q       <= '0;
      act_q_valid <= 1'b0;
      acc         <= '0;
      res_data    <= '0;
    end else begin
      act_q_valid <= fire;
      if (fire) begin
        act_q <= act_data;
        idx   <= idx + CNT_W'(1);
      end

      if ((state == IDLE) && start) begin
        base_q   <= base_addr;
        n_q      <= num_inputs;
        relu_q   <= relu_en;
        idx      <= '0;
        acc      <= '0;
        res_data <= '0;
      end else if (mul_valid) begin
        acc <= acc + mul_p;
      end

      // Result is captured once on entry to RESULT and held until accepted.
      if ((state == DRAIN) && (next_state == RESULT)) begin
        res_data <= saturate(acc, relu_q);
      end
    end
  end

  // The weight arrives one cycle after the handshake, aligned with act_q.
  fxp_mul_q16 #(
    .DATA_W (DATA_W),
    .FRAC   (FRAC)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (act_q_valid),
    .a         (ram_dout),
    .b         (act_q),
    .out_valid (mul_valid),
    .p         (mul_p)
  );

endmodule
